wb_cfg_initiator: RTL and testbench

Wishbone initiator that converts single-register command requests into Wishbone transactions toward the LVDS driver configuration responder (delay sync/P/N and drive-current registers at 0x0300_0000..0x0300_0003). A calibration or boot sequencer feeds it through a valid/ready command channel. Each command becomes exactly one Wishbone read or write, with stall handling and an ack timeout. Completion status and read data return on a valid/ready response channel.

---
 rtl/wb_cfg_initiator.sv | 157 +++++++++++++++
 tb/tb_wb_cfg_initiator.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cfg_initiator.sv
// Single-register Wishbone initiator for the LVDS driver configuration block.
// One command in, one Wishbone cycle out, one response back, with ack timeout.
module wb_cfg_initiator #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_timeout,
    output logic [7:0]  o_timeout_cnt,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_n;
    logic [7:0]  tmo;
    logic [7:0]  tmo_n;
    logic        cmd_ready_n;
    logic        cyc_n;
    logic        stb_n;
    logic        we_n;
    logic [31:0] addr_n;
    logic [31:0] data_n;
    logic        rsp_valid_n;
    logic [31:0] rsp_rdata_n;
    logic        rsp_timeout_n;
    logic [7:0]  timeout_cnt_n;
    logic        in_txn;
    logic        done;
    logic        expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            tmo           <= 8'd0;
            o_cmd_ready   <= 1'b0;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_wb_we       <= 1'b0;
            o_wb_addr     <= 32'd0;
            o_wb_data     <= 32'd0;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= 32'd0;
            o_rsp_timeout <= 1'b0;
            o_timeout_cnt <= 8'd0;
        end else begin
            state         <= state_n;
            tmo           <= tmo_n;
            o_cmd_ready   <= cmd_ready_n;
            o_wb_cyc      <= cyc_n;
            o_wb_stb      <= stb_n;
            o_wb_we       <= we_n;
            o_wb_addr     <= addr_n;
            o_wb_data     <= data_n;
            o_rsp_valid   <= rsp_valid_n;
            o_rsp_rdata   <= rsp_rdata_n;
            o_rsp_timeout <= rsp_timeout_n;
            o_timeout_cnt <= timeout_cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        tmo_n         = tmo;
        cmd_ready_n   = o_cmd_ready;
        cyc_n         = o_wb_cyc;
        stb_n         = o_wb_stb;
        we_n          = o_wb_we;
        addr_n        = o_wb_addr;
        data_n        = o_wb_data;
        rsp_valid_n   = o_rsp_valid;
        rsp_rdata_n   = o_rsp_rdata;
        rsp_timeout_n = o_rsp_timeout;
        timeout_cnt_n = o_timeout_cnt;
        in_txn        = 1'b0;
        done          = 1'b0;
        expired       = (tmo == LAST_CNT);

        unique case (state)
            IDLE: begin
                cmd_ready_n = 1'b1;
                if (o_cmd_ready && i_cmd_valid) begin
                    cmd_ready_n = 1'b0;
                    cyc_n       = 1'b1;
                    stb_n       = 1'b1;
                    we_n        = i_cmd_we;
                    addr_n      = i_cmd_addr;
                    data_n      = i_cmd_wdata;
                    tmo_n       = 8'd0;
                    state_n     = REQ;
                end
            end
            REQ: begin
                in_txn = 1'b1;
                tmo_n  = tmo + 8'd1;
                // An ack only counts once the strobe has actually been taken.
                done   = i_wb_ack && !i_wb_stall;
                if (!i_wb_stall) begin
                    stb_n   = 1'b0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                in_txn = 1'b1;
                tmo_n  = tmo + 8'd1;
                done   = i_wb_ack;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Completion and abort share the same exit; ack wins a tie.
        if (in_txn && (done || expired)) begin
            cyc_n         = 1'b0;
            stb_n         = 1'b0;
            rsp_valid_n   = 1'b1;
            rsp_timeout_n = !done;
            rsp_rdata_n   = (done && !o_wb_we) ? i_wb_data : 32'd0;
            if (!done && o_timeout_cnt != 8'hFF) begin
                timeout_cnt_n = o_timeout_cnt + 8'd1;
            end
            state_n = RESP;
        end
    end

endmodule

// File: tb/tb_wb_cfg_initiator.sv
// Bench for wb_cfg_initiator: behavioural register responder plus
// a response scoreboard fed at command time.
module tb_wb_cfg_initiator;

    logic        clk;
    logic        reset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_timeout;
    logic [7:0]  o_timeout_cnt;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic [31:0] i_wb_data;

    logic        resp_ack;
    logic [31:0] resp_data;
    logic        force_ack;
    logic        ack_en;
    logic [31:0] mem [4] = '{32'hA5A5_0000, 32'h1111_1111,
                             32'hC3C3_3C3C, 32'h0000_0001};

    logic [32:0] exp_q [$];
    int          n_vec;
    int          n_err;

    wb_cfg_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_we     (i_cmd_we),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_wdata  (i_cmd_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_timeout(o_rsp_timeout),
        .o_timeout_cnt(o_timeout_cnt),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .o_wb_we      (o_wb_we),
        .o_wb_addr    (o_wb_addr),
        .o_wb_data    (o_wb_data),
        .i_wb_ack     (i_wb_ack),
        .i_wb_stall   (i_wb_stall),
        .i_wb_data    (i_wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_wb_ack  = resp_ack | force_ack;
    assign i_wb_data = resp_data;

    // Responder: acks the cycle after an accepted strobe to 0x0300_0000..3.
    always @(posedge clk) begin
        if (reset) begin
            resp_ack  <= 1'b0;
            resp_data <= 32'd0;
        end else begin
            resp_ack <= 1'b0;
            if (ack_en && o_wb_cyc && o_wb_stb && !i_wb_stall &&
                o_wb_addr[31:2] == 30'h00C0_0000) begin
                resp_ack  <= 1'b1;
                resp_data <= o_wb_we ? 32'd0 : mem[o_wb_addr[1:0]];
                if (o_wb_we) mem[o_wb_addr[1:0]] <= o_wb_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
        i_cmd_valid = 1'b1;
        i_cmd_we    = we;
        i_cmd_addr  = addr;
        i_cmd_wdata = wdata;
        step();
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start, output int cyc, output bit ok);
        cyc = start;
        ok  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (o_rsp_valid) begin
                ok = 1'b1;
                break;
            end
            step();
            cyc++;
        end
    endtask

    task automatic consume();
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid, o_rsp_timeout} !== 5'b0 ||
            o_wb_addr !== 32'd0 || o_wb_data !== 32'd0 ||
            o_rsp_rdata !== 32'd0 || o_timeout_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_vals: got cyc%b stb%b we%b v%b to%b a%h d%h r%h n%0d want all 0",
                     o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid, o_rsp_timeout,
                     o_wb_addr, o_wb_data, o_rsp_rdata, o_timeout_cnt);
        end
        reset = 1'b0;
        step();
        n_vec++;
        if (o_cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", o_cmd_ready);
        end
    endtask

    task automatic test_write();
        int          c;
        bit          ok;
        logic [32:0] e;
        n_vec++;
        if (o_cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_ready: got %b want 1", o_cmd_ready);
        end
        exp_q.push_back({1'b0, 32'd0});
        send(1'b1, 32'h0300_0001, 32'h00FF_0F0F);
        n_vec++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we} !== 3'b111 ||
            o_wb_addr !== 32'h0300_0001 || o_wb_data !== 32'h00FF_0F0F) begin
            n_err++;
            $display("FAIL wr_bus_c1: got ctl %b a %h d %h want 111 03000001 00ff0f0f",
                     {o_wb_cyc, o_wb_stb, o_wb_we}, o_wb_addr, o_wb_data);
        end
        step();
        n_vec++;
        if ({o_wb_cyc, o_wb_stb} !== 2'b10) begin
            n_err++;
            $display("FAIL wr_stb_c2: got cyc/stb %b want 10", {o_wb_cyc, o_wb_stb});
        end
        wait_rsp(2, c, ok);
        n_vec++;
        if (!ok || c != 3 || o_wb_cyc !== 1'b0) begin
            n_err++;
            $display("FAIL wr_latency: got cycle %0d cyc %b want 3 0", c, o_wb_cyc);
        end
        e = exp_q.pop_front();
        n_vec++;
        if ({o_rsp_timeout, o_rsp_rdata} !== e) begin
            n_err++;
            $display("FAIL wr_rsp: got %h want %h", {o_rsp_timeout, o_rsp_rdata}, e);
        end
        consume();
        n_vec++;
        if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_after: got valid %b ready %b want 0 1",
                     o_rsp_valid, o_cmd_ready);
        end
    endtask

    task automatic test_read();
        logic [31:0] addrs [2] = '{32'h0300_0003, 32'h0300_0001};
        logic [31:0] datas [2] = '{32'h0000_0001, 32'h00FF_0F0F};
        int          c;
        bit          ok;
        logic [32:0] e;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({1'b0, datas[k]});
            send(1'b0, addrs[k], 32'hDEAD_BEEF);
            wait_rsp(1, c, ok);
            n_vec++;
            if (!ok || c != 3) begin
                n_err++;
                $display("FAIL rd_latency[%0d]: got cycle %0d ok %b want 3", k, c, ok);
            end
            e = exp_q.pop_front();
            n_vec++;
            if ({o_rsp_timeout, o_rsp_rdata} !== e) begin
                n_err++;
                $display("FAIL rd_rsp[%0d]: got %h want %h", k,
                         {o_rsp_timeout, o_rsp_rdata}, e);
            end
            consume();
        end
    endtask

    task automatic test_stall();
        int          c;
        bit          ok;
        logic [32:0] e;
        exp_q.push_back({1'b0, 32'hA5A5_0000});
        send(1'b0, 32'h0300_0000, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            i_wb_stall = (k <= 3);
            n_vec++;
            if ({o_wb_cyc, o_wb_stb} !== 2'b11 || o_wb_addr !== 32'h0300_0000) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got cyc/stb %b a %h want 11 03000000",
                         k, {o_wb_cyc, o_wb_stb}, o_wb_addr);
            end
            step();
        end
        i_wb_stall = 1'b0;
        n_vec++;
        if (o_wb_stb !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: got stb %b want 0", o_wb_stb);
        end
        wait_rsp(5, c, ok);
        n_vec++;
        if (!ok || c != 6) begin
            n_err++;
            $display("FAIL stall_latency: got cycle %0d ok %b want 6", c, ok);
        end
        e = exp_q.pop_front();
        n_vec++;
        if ({o_rsp_timeout, o_rsp_rdata} !== e) begin
            n_err++;
            $display("FAIL stall_rsp: got %h want %h", {o_rsp_timeout, o_rsp_rdata}, e);
        end
        consume();
    endtask

    task automatic test_timeout();
        int          hi;
        logic [32:0] e;
        hi = 0;
        exp_q.push_back({1'b1, 32'd0});
        send(1'b0, 32'h0300_0010, 32'd0);
        for (int i = 0; i < 100; i++) begin
            if (!o_wb_cyc) break;
            hi++;
            step();
        end
        n_vec++;
        if (hi != 16) begin
            n_err++;
            $display("FAIL to_cyc_len: got %0d want 16", hi);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (o_rsp_valid !== 1'b1 || {o_rsp_timeout, o_rsp_rdata} !== e ||
            o_timeout_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL to_rsp: got v%b %h cnt %0d want v1 %h cnt 1",
                     o_rsp_valid, {o_rsp_timeout, o_rsp_rdata}, o_timeout_cnt, e);
        end
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        n_vec++;
        if (o_rsp_valid !== 1'b1 || o_rsp_timeout !== 1'b1 || o_wb_cyc !== 1'b0 ||
            o_rsp_rdata !== 32'd0 || o_timeout_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL to_late_ack_resp: got v%b to%b cyc%b r%h n%0d want 1 1 0 0 1",
                     o_rsp_valid, o_rsp_timeout, o_wb_cyc, o_rsp_rdata, o_timeout_cnt);
        end
        consume();
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        n_vec++;
        if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_wb_cyc !== 1'b0) begin
            n_err++;
            $display("FAIL to_late_ack_idle: got ready%b v%b cyc%b want 1 0 0",
                     o_cmd_ready, o_rsp_valid, o_wb_cyc);
        end
    endtask

    task automatic test_backpressure();
        int          c;
        bit          ok;
        logic [32:0] e;
        exp_q.push_back({1'b0, 32'hC3C3_3C3C});
        send(1'b0, 32'h0300_0002, 32'd0);
        wait_rsp(1, c, ok);
        e = exp_q.pop_front();
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL bp_no_rsp: got none within bound want rsp_valid");
        end
        i_cmd_valid = 1'b1;
        i_cmd_we    = 1'b1;
        i_cmd_addr  = 32'h0300_0000;
        i_cmd_wdata = 32'h5555_AAAA;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (o_rsp_valid !== 1'b1 || o_cmd_ready !== 1'b0 ||
                {o_rsp_timeout, o_rsp_rdata} !== e) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v%b rdy%b %h want v1 rdy0 %h",
                         k, o_rsp_valid, o_cmd_ready, {o_rsp_timeout, o_rsp_rdata}, e);
            end
            step();
        end
        i_cmd_valid = 1'b0;
        consume();
        n_vec++;
        if (o_wb_addr !== 32'h0300_0002 || o_wb_we !== 1'b0 || o_rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_no_accept: got a %h we %b v %b want 03000002 0 0",
                     o_wb_addr, o_wb_we, o_rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] model [3] = '{32'hA5A5_0000, 32'h00FF_0F0F, 32'hC3C3_3C3C};
        int          acc;
        int          rsps;
        logic [32:0] e;
        acc  = 0;
        rsps = 0;
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            i_cmd_valid = 1'b1;
            i_cmd_we    = 1'b0;
            i_cmd_addr  = 32'h0300_0000 | 32'(acc % 3);
            if (o_cmd_ready) begin
                exp_q.push_back({1'b0, model[acc % 3]});
                acc++;
            end
            if (o_rsp_valid) begin
                e = exp_q.pop_front();
                rsps++;
                n_vec++;
                if ({o_rsp_timeout, o_rsp_rdata} !== e) begin
                    n_err++;
                    $display("FAIL b2b_rsp[%0d]: got %h want %h", rsps,
                             {o_rsp_timeout, o_rsp_rdata}, e);
                end
            end
            step();
        end
        i_cmd_valid = 1'b0;
        i_rsp_ready = 1'b0;
        n_vec++;
        if (acc != 3 || rsps != 3) begin
            n_err++;
            $display("FAIL b2b_rate: got %0d accepts %0d rsps want 3 3", acc, rsps);
        end
    endtask

    task automatic test_reset_mid();
        ack_en = 1'b0;
        send(1'b0, 32'h0300_0000, 32'd0);
        step();
        n_vec++;
        if ({o_wb_cyc, o_wb_stb} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_mid_wait: got cyc/stb %b want 10", {o_wb_cyc, o_wb_stb});
        end
        reset = 1'b1;
        step();
        n_vec++;
        if ({o_wb_cyc, o_wb_stb, o_rsp_valid} !== 3'b000 || o_timeout_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL rst_mid_drop: got cyc/stb/v %b cnt %0d want 000 0",
                     {o_wb_cyc, o_wb_stb, o_rsp_valid}, o_timeout_cnt);
        end
        reset  = 1'b0;
        ack_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_vec++;
            if (o_rsp_valid !== 1'b0 || o_wb_cyc !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_quiet[%0d]: got v%b cyc%b want 0 0",
                         k, o_rsp_valid, o_wb_cyc);
            end
        end
        n_vec++;
        if (o_cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_ready: got %b want 1", o_cmd_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_we    = 1'b0;
        i_cmd_addr  = 32'd0;
        i_cmd_wdata = 32'd0;
        i_rsp_ready = 1'b0;
        i_wb_stall  = 1'b0;
        force_ack   = 1'b0;
        ack_en      = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
